uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the FIFO depth in bytes; legal values are powers of two from 2 to 256.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the pointer width; it SHALL equal log2(DEPTH).
REQ-003 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port i_Reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_Wr_DV, input, 1 bit: write strobe; one byte is offered per cycle it is high.
REQ-006 The block SHALL have port i_Wr_Byte, input, 8 bits: the byte to write, sampled when i_Wr_DV=1.
REQ-007 The block SHALL have port o_Full, output, 1 bit: high when the count equals DEPTH.
REQ-008 The block SHALL have port o_Empty, output, 1 bit: high when the count equals 0.
REQ-009 The block SHALL have port o_Count, output, ADDR_W+1 bits: the number of bytes stored.
REQ-010 The block SHALL have port o_Overflow, output, 1 bit: one-cycle pulse when a write is dropped.
REQ-011 The block SHALL have port o_Busy, output, 1 bit: high whenever the FSM is not in S_IDLE.
REQ-012 The block SHALL have port o_Tx_DV, output, 1 bit: start strobe to the UART transmitter.
REQ-013 The block SHALL have port o_Tx_Byte, output, 8 bits: the byte presented to the transmitter; it SHALL be stable while o_Tx_DV=1.
REQ-014 The block SHALL have port i_Tx_Active, input, 1 bit: the transmitter's frame-in-progress flag.
REQ-015 The block SHALL have port i_Tx_Done, input, 1 bit: the transmitter's done flag, which may stay high for more than one cycle.

Function
REQ-016 Storage SHALL be a DEPTH x 8 circular buffer with ADDR_W-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-017 A write SHALL be accepted when i_Wr_DV=1 and o_Full=0 (registered value): the byte is stored at the write pointer, the write pointer advances, and the count increments.
REQ-018 A write with i_Wr_DV=1 and o_Full=1 SHALL be dropped, leaving pointers and count unchanged, and o_Overflow SHALL be high on the next cycle for exactly one cycle.
REQ-019 A pop (REQ-022) SHALL advance the read pointer and decrement the count.
REQ-020 An accepted write and a pop in the same cycle SHALL leave the count unchanged; both pointers SHALL advance.
REQ-021 The FSM SHALL have states S_IDLE, S_WAIT_ACTIVE, S_WAIT_DONE and S_WAIT_RELEASE, encoded on 2 bits; any unused encoding SHALL go to S_IDLE.
REQ-022 S_IDLE: when o_Empty=0, i_Tx_Active=0 and i_Tx_Done=0, the FSM SHALL register o_Tx_Byte with the byte at the read pointer, set o_Tx_DV=1, pop, and go to S_WAIT_ACTIVE.
REQ-023 S_WAIT_ACTIVE: o_Tx_DV SHALL be held at 1 and o_Tx_Byte held stable; when i_Tx_Active=1, o_Tx_DV SHALL be cleared and the FSM SHALL go to S_WAIT_DONE.
REQ-024 S_WAIT_DONE: the FSM SHALL remain in this state until i_Tx_Done=1, then go to S_WAIT_RELEASE.
REQ-025 S_WAIT_RELEASE: the FSM SHALL remain in this state until i_Tx_Done=0, then go to S_IDLE, so a multi-cycle done pulse counts as a single completion.
REQ-026 Latency: a write at cycle N into an empty FIFO with the transmitter idle SHALL produce o_Tx_DV=1 at cycle N+2.
REQ-027 Back-to-back bytes SHALL be issued with no bytes lost or reordered; the next o_Tx_DV SHALL rise no earlier than one cycle after i_Tx_Done falls.
REQ-028 Writes SHALL be accepted in every FSM state, including while a frame is in flight.

Reset
REQ-029 While i_Reset=1 at a clock edge, the pointers and count SHALL be cleared to 0, the FSM SHALL enter S_IDLE, and the outputs SHALL be o_Tx_DV=0, o_Tx_Byte=0x00, o_Overflow=0, o_Busy=0, o_Empty=1, o_Full=0, o_Count=0.
REQ-030 Writes presented while i_Reset=1 SHALL be ignored.
REQ-031 Reset mid-frame SHALL discard all queued bytes; because the transmitter is not reset, the block SHALL issue no new o_Tx_DV until i_Tx_Active=0 and i_Tx_Done=0 (enforced by REQ-022).

Verification
REQ-032 Single byte: write 0x55 into an empty FIFO -> o_Tx_DV at N+2 with o_Tx_Byte=0x55; after the 87-clock-per-bit frame, o_Busy=0 and o_Empty=1.
REQ-033 Burst: write 0x01..0x10 on 16 consecutive cycles -> o_Count peaks at 15 or 16, no overflow, and the serial output decodes 0x01..0x10 in order.
REQ-034 Overflow: hold the transmitter busy, write 17 bytes -> o_Full=1, the 17th byte is dropped, o_Overflow pulses once, and o_Count=16.
REQ-035 Simultaneous events: at count=3, write during the pop cycle -> o_Count stays 3 and byte order is preserved across pointer wrap (run more than DEPTH bytes).
REQ-036 Done handling: drive i_Tx_Done high for 2 cycles -> exactly one pop, and the next o_Tx_DV only after i_Tx_Done=0.
REQ-037 Reset mid-frame: queue 5 bytes, assert i_Reset during the third frame -> FIFO empty, o_Tx_DV=0, and no new o_Tx_DV until the in-flight frame's i_Tx_Done has fallen.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte-write and transmitter-handshake bundle for uart_tx_fifo.
// The FIFO connects through slave; the producer/transmitter side uses master.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              i_Wr_DV;
  logic [7:0]        i_Wr_Byte;
  logic              o_Full;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overflow;
  logic              o_Busy;
  logic              o_Tx_DV;
  logic [7:0]        o_Tx_Byte;
  logic              i_Tx_Active;
  logic              i_Tx_Done;

  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
  );

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
    output o_Full, o_Empty, o_Count, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: queues writes and hands bytes
// to the transmitter one frame at a time using its active/done flags.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  uart_tx_fifo_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_ACTIVE  = 2'd1,
    S_WAIT_DONE    = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              overflow_reg;
  state_t            state_reg;
  state_t            state_next;
  logic              tx_dv_reg;
  logic              tx_dv_next;
  logic [7:0]        tx_byte_reg;
  logic              full;
  logic              empty;
  logic              wr_accept;
  logic              pop;

  assign full      = (count_reg == FULL_COUNT);
  assign empty     = (count_reg == '0);
  assign wr_accept = bus.i_Wr_DV && !full;

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge i_Clock) begin
    if (wr_accept && !i_Reset) begin
      mem[wr_ptr_reg] <= bus.i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      case ({wr_accept, pop})
        2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
      overflow_reg <= bus.i_Wr_DV && full;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_reg   <= S_IDLE;
      tx_dv_reg   <= 1'b0;
      tx_byte_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      tx_dv_reg <= tx_dv_next;
      if (pop) begin
        tx_byte_reg <= mem[rd_ptr_reg];
      end
    end
  end

  // A new frame starts only with the transmitter fully quiet, which also
  // covers a frame still in flight after this block was reset.
  always_comb begin
    state_next = state_reg;
    tx_dv_next = tx_dv_reg;
    pop        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!empty && !bus.i_Tx_Active && !bus.i_Tx_Done) begin
          pop        = 1'b1;
          tx_dv_next = 1'b1;
          state_next = S_WAIT_ACTIVE;
        end
      end
      S_WAIT_ACTIVE: begin
        if (bus.i_Tx_Active) begin
          tx_dv_next = 1'b0;
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.i_Tx_Done) begin
          state_next = S_WAIT_RELEASE;
        end
      end
      S_WAIT_RELEASE: begin
        if (!bus.i_Tx_Done) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_dv_next = 1'b0;
      end
    endcase
  end

  assign bus.o_Full     = full;
  assign bus.o_Empty    = empty;
  assign bus.o_Count    = count_reg;
  assign bus.o_Overflow = overflow_reg;
  assign bus.o_Busy     = (state_reg != S_IDLE);
  assign bus.o_Tx_DV    = tx_dv_reg;
  assign bus.o_Tx_Byte  = tx_byte_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter model and
// a byte scoreboard filled on write and drained when a frame starts.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  logic clk;
  logic rst;
  logic m_active;
  logic m_done;
  logic force_active;
  int   m_state;
  int   m_cnt;
  int   bit_clks;
  int   done_len;
  int   n_starts;
  int   dv_viol;
  int   n_checks;
  int   n_errors;
  logic [7:0] exp_q[$];

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  assign bus.i_Tx_Active = m_active | force_active;
  assign bus.i_Tx_Done   = m_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: accepts a start strobe, holds active for a 10-bit
  // frame, then raises done for done_len cycles. Not affected by DUT reset.
  initial begin
    logic [31:0] exp_b;
    m_state  = M_IDLE;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_cnt    = 0;
    n_starts = 0;
    dv_viol  = 0;
    forever begin
      @(negedge clk);
      if (m_state != M_IDLE && bus.o_Tx_DV === 1'b1) dv_viol++;
      case (m_state)
        M_IDLE: begin
          if (bus.o_Tx_DV === 1'b1) begin
            n_starts++;
            exp_b = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'hxxxx_xxxx;
            check("tx_byte_order", {24'h0, bus.o_Tx_Byte}, exp_b);
            $display("tx start %0d: byte 0x%02h", n_starts, bus.o_Tx_Byte);
            m_active = 1'b1;
            m_cnt    = 0;
            m_state  = M_BUSY;
          end
        end
        M_BUSY: begin
          m_cnt++;
          if (m_cnt >= 10 * bit_clks) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_cnt    = 0;
            m_state  = M_DONE;
          end
        end
        default: begin
          m_cnt++;
          if (m_cnt >= done_len) begin
            m_done  = 1'b0;
            m_state = M_IDLE;
          end
        end
      endcase
    end
  end

  task automatic write_byte(input logic [7:0] b);
    int i = 0;
    while (bus.o_Full === 1'b1 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 2000) check("write_wait_timeout", i, 0);
    bus.i_Wr_DV   = 1'b1;
    bus.i_Wr_Byte = b;
    exp_q.push_back(b);
    @(negedge clk);
    bus.i_Wr_DV = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while (!(bus.o_Empty === 1'b1 && bus.o_Busy === 1'b0 && m_state == M_IDLE) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_drain_in_time"}, (i < budget), 1);
    check({tag, "_busy"}, bus.o_Busy, 0);
    check({tag, "_empty"}, bus.o_Empty, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int peak;
    int ovf_seen;
    int starts0;
    int i;
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    force_active  = 1'b0;
    bus.i_Wr_DV   = 1'b0;
    bus.i_Wr_Byte = 8'h00;
    bit_clks      = 87;
    done_len      = 1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_dv", bus.o_Tx_DV, 0);
    check("rst_tx_byte", bus.o_Tx_Byte, 8'h00);
    check("rst_overflow", bus.o_Overflow, 0);
    check("rst_busy", bus.o_Busy, 0);
    check("rst_empty", bus.o_Empty, 1);
    check("rst_full", bus.o_Full, 0);
    check("rst_count", bus.o_Count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte, 87 clocks per bit: strobe two cycles after the write
    bus.i_Wr_DV   = 1'b1;
    bus.i_Wr_Byte = 8'h55;
    exp_q.push_back(8'h55);
    @(negedge clk);
    bus.i_Wr_DV = 1'b0;
    check("single_n1_tx_dv", bus.o_Tx_DV, 0);
    check("single_n1_count", bus.o_Count, 1);
    check("single_n1_empty", bus.o_Empty, 0);
    @(negedge clk);
    check("single_n2_tx_dv", bus.o_Tx_DV, 1);
    check("single_n2_tx_byte", bus.o_Tx_Byte, 8'h55);
    check("single_n2_busy", bus.o_Busy, 1);
    check("single_n2_count", bus.o_Count, 0);
    wait_drain("single", 1200);

    // Burst of 16 consecutive writes with the transmitter idle
    bit_clks = 4;
    peak     = 0;
    ovf_seen = 0;
    for (int b = 1; b <= 16; b++) begin
      bus.i_Wr_DV   = 1'b1;
      bus.i_Wr_Byte = 8'(b);
      exp_q.push_back(8'(b));
      @(negedge clk);
      if (int'(bus.o_Count) > peak) peak = int'(bus.o_Count);
      if (bus.o_Overflow === 1'b1) ovf_seen++;
    end
    bus.i_Wr_DV = 1'b0;
    $display("burst: peak count %0d", peak);
    check("burst_peak_15_or_16", (peak == 15 || peak == 16), 1);
    check("burst_no_overflow", ovf_seen, 0);
    wait_drain("burst", 2000);

    // Overflow with the transmitter held busy
    force_active = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 17; b++) begin
      bus.i_Wr_DV   = 1'b1;
      bus.i_Wr_Byte = 8'(8'h80 + b);
      if (b < 16) exp_q.push_back(8'(8'h80 + b));
      @(negedge clk);
      if (b == 15) begin
        check("ovf_full", bus.o_Full, 1);
        check("ovf_count16", bus.o_Count, 16);
        check("ovf_not_yet", bus.o_Overflow, 0);
      end
    end
    bus.i_Wr_DV = 1'b0;
    check("ovf_pulse", bus.o_Overflow, 1);
    check("ovf_count_kept", bus.o_Count, 16);
    @(negedge clk);
    check("ovf_pulse_single", bus.o_Overflow, 0);
    check("ovf_count_after", bus.o_Count, 16);
    force_active = 1'b0;
    wait_drain("ovf", 2000);

    // Write in the pop cycle at count 3, then run past a pointer wrap
    force_active = 1'b1;
    for (int b = 0; b < 3; b++) write_byte(8'(8'hC0 + b));
    check("simul_pre_count", bus.o_Count, 3);
    force_active  = 1'b0;
    bus.i_Wr_DV   = 1'b1;
    bus.i_Wr_Byte = 8'hC3;
    exp_q.push_back(8'hC3);
    @(negedge clk);
    bus.i_Wr_DV = 1'b0;
    check("simul_count_held", bus.o_Count, 3);
    check("simul_tx_dv", bus.o_Tx_DV, 1);
    check("simul_tx_byte", bus.o_Tx_Byte, 8'hC0);
    for (int b = 0; b < 20; b++) write_byte(8'(8'h20 + b));
    wait_drain("wrap", 3000);

    // Two-cycle done pulse must complete exactly one frame each
    done_len = 2;
    starts0  = n_starts;
    for (int b = 0; b < 3; b++) write_byte(8'(8'hD0 + b));
    wait_drain("done2", 1000);
    check("done2_starts", n_starts - starts0, 3);
    check("done2_no_early_dv", dv_viol, 0);
    done_len = 1;

    // Reset during the third of five queued frames
    starts0 = n_starts;
    for (int b = 0; b < 5; b++) write_byte(8'(8'hE1 + b));
    i = 0;
    while (n_starts < starts0 + 3 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check("mid_reach_third", n_starts - starts0, 3);
    repeat (5) @(negedge clk);
    rst           = 1'b1;
    bus.i_Wr_DV   = 1'b1;
    bus.i_Wr_Byte = 8'hEE;
    @(negedge clk);
    rst         = 1'b0;
    bus.i_Wr_DV = 1'b0;
    exp_q.delete();
    check("mid_rst_empty", bus.o_Empty, 1);
    check("mid_rst_count", bus.o_Count, 0);
    check("mid_rst_tx_dv", bus.o_Tx_DV, 0);
    check("mid_rst_busy", bus.o_Busy, 0);
    check("mid_rst_full", bus.o_Full, 0);
    check("mid_rst_tx_byte", bus.o_Tx_Byte, 8'h00);
    write_byte(8'hA5);
    @(negedge clk);
    check("mid_hold_while_active", bus.o_Tx_DV, 0);
    check("mid_hold_count", bus.o_Count, 1);
    wait_drain("mid", 1000);
    check("mid_starts", n_starts - starts0, 4);
    check("final_no_early_dv", dv_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
